div_seq: RTL and testbench

Multi-cycle integer divider for the MIPS datapath. It is the inverse-operation companion of the sequential Booth multiplier and serves DIV, and DIVU when the optional feature is compiled in. It uses the same start/stop handshake as the multiplier. It delivers the quotient to LO and the remainder to HI, one quotient bit per cycle, using restoring division on magnitudes. The control unit pulses start, waits for stop, then latches HI/LO or raises the divide-by-zero exception.

---
 rtl/div_seq.sv | 169 ++++++++++++++++
 tb/tb_div_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq : multi-cycle restoring integer divider for the MIPS datapath.
//
// Companion of the sequential Booth multiplier and uses the same start/stop
// handshake. A start pulse in IDLE captures the operands. One quotient bit is
// produced per clock on the operand magnitudes. A final FIX cycle restores
// the signs and writes quotient -> w_DIVLO and remainder -> w_DIVHI.
//
// Ports:
//   Clock          system clock, rising edge
//   Reset          synchronous, active-high reset
//   w_DivStart     one-cycle start request, only honoured in IDLE
//   w_DivUnsigned  (DIV_UNSIGNED_EN only) treat operands as unsigned (DIVU)
//   w_A            dividend (rs), sampled at start
//   w_B            divisor (rt), sampled at start
//   w_DivStop      one-cycle completion pulse
//   w_DIVHI        remainder, held until next completion or reset
//   w_DIVLO        quotient, held until next completion or reset
//   w_DivZero      divisor was zero; valid together with w_DivStop
//
// Configuration macro: DIV_UNSIGNED_EN adds the w_DivUnsigned port and the
// DIVU path. Leave it undefined for a signed-only divider.
// ---------------------------------------------------------------------------
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             w_DivStart,
`ifdef DIV_UNSIGNED_EN
   input  logic             w_DivUnsigned,
`endif
   input  logic [WIDTH-1:0] w_A,
   input  logic [WIDTH-1:0] w_B,
   output logic             w_DivStop,
   output logic [WIDTH-1:0] w_DIVHI,
   output logic [WIDTH-1:0] w_DIVLO,
   output logic             w_DivZero
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   quo_q;
   logic [WIDTH-1:0]   divisor_q;
   logic [WIDTH-1:0]   rem_q;
   logic               signA_q;
   logic               signB_q;
   logic               zeroPend_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               stop_q;
   logic               zero_q;

   logic               aNeg;
   logic               bNeg;
   logic [WIDTH-1:0]   aMag;
   logic [WIDTH-1:0]   bMag;
   logic [WIDTH:0]     remShift;
   logic [WIDTH:0]     remDiff;
   logic               takeBit;
   logic [WIDTH-1:0]   rem_d;
   logic [WIDTH-1:0]   quo_d;

   // Operand conditioning at start. The magnitude of the most negative value
   // wraps back onto itself, which is exactly the right unsigned magnitude.
   // In DIVU mode the sign flags are forced low so the operands pass through.
   always_comb begin
`ifdef DIV_UNSIGNED_EN
      aNeg = w_A[WIDTH-1] & ~w_DivUnsigned;
      bNeg = w_B[WIDTH-1] & ~w_DivUnsigned;
`else
      aNeg = w_A[WIDTH-1];
      bNeg = w_B[WIDTH-1];
`endif
      aMag = aNeg ? (~w_A + 1'b1) : w_A;
      bMag = bNeg ? (~w_B + 1'b1) : w_B;
   end

   // One restoring step. The shifted partial remainder needs WIDTH+1 bits
   // because it can reach almost twice the divisor. The top bit of the trial
   // difference acts as the borrow: clear means remainder >= divisor.
   always_comb begin
      remShift = {rem_q, quo_q[WIDTH-1]};
      remDiff  = remShift - {1'b0, divisor_q};
      takeBit  = ~remDiff[WIDTH];
      rem_d    = takeBit ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
      quo_d    = {quo_q[WIDTH-2:0], takeBit};
   end

   // Control FSM and datapath registers. A zero divisor skips the iteration
   // and parks in DONE for one extra cycle, so the stop/zero pulse appears
   // one edge after the start was sampled.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         quo_q      <= '0;
         divisor_q  <= '0;
         rem_q      <= '0;
         signA_q    <= 1'b0;
         signB_q    <= 1'b0;
         zeroPend_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         stop_q     <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               stop_q <= 1'b0;
               zero_q <= 1'b0;
               if (w_DivStart) begin
                  signA_q   <= aNeg;
                  signB_q   <= bNeg;
                  quo_q     <= aMag;
                  divisor_q <= bMag;
                  rem_q     <= '0;
                  cnt_q     <= CNT_W'(WIDTH - 1);
                  if (w_B == '0) begin
                     zeroPend_q <= 1'b1;
                     state_q    <= DONE;
                  end else begin
                     state_q    <= CALC;
                  end
               end
            end
            CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == '0) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               lo_q    <= (signA_q ^ signB_q) ? (~quo_q + 1'b1) : quo_q;
               hi_q    <= signA_q ? (~rem_q + 1'b1) : rem_q;
               stop_q  <= 1'b1;
               zero_q  <= 1'b0;
               state_q <= DONE;
            end
            DONE: begin
               if (zeroPend_q) begin
                  stop_q     <= 1'b1;
                  zero_q     <= 1'b1;
                  zeroPend_q <= 1'b0;
               end else begin
                  stop_q  <= 1'b0;
                  zero_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign w_DivStop = stop_q;
   assign w_DivZero = zero_q;
   assign w_DIVHI   = hi_q;
   assign w_DIVLO   = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq : self-checking bench for div_seq (WIDTH = 32).
//
// The driver issues directed divisions with hand-computed results and pushes
// the expected quotient, remainder, zero flag and stop cycle into a queue.
// A separate monitor pops one entry per w_DivStop pulse and compares.
// With DIV_UNSIGNED_EN defined the bench also exercises the DIVU path.
// ---------------------------------------------------------------------------
module tb_div_seq;

   logic        Clock;
   logic        Reset;
   logic        w_DivStart;
   logic [31:0] w_A;
   logic [31:0] w_B;
   logic        w_DivStop;
   logic [31:0] w_DIVHI;
   logic [31:0] w_DIVLO;
   logic        w_DivZero;
`ifdef DIV_UNSIGNED_EN
   logic        divUns;
`endif

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        zero;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   nCmp = 0;
   int   nMis = 0;
   int   cyc  = 0;

   div_seq #(.WIDTH(32)) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .w_DivStart   (w_DivStart),
`ifdef DIV_UNSIGNED_EN
      .w_DivUnsigned(divUns),
`endif
      .w_A          (w_A),
      .w_B          (w_B),
      .w_DivStop    (w_DivStop),
      .w_DIVHI      (w_DIVHI),
      .w_DIVLO      (w_DIVLO),
      .w_DivZero    (w_DivZero)
   );

   // Free-running 10-unit clock.
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Edge counter used to check stop latency against the sampling edge.
   always @(posedge Clock) begin
      cyc <= cyc + 1;
   end

   // Single comparison point: every check goes through here.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nMis++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every stop pulse must match the oldest outstanding expectation.
   // A pulse with nothing outstanding (or a pulse lasting two cycles) fails.
   always @(negedge Clock) begin : monitor
      exp_t e;
      if (!Reset && w_DivStop === 1'b1) begin
         if (sb.size() == 0) begin
            nCmp++;
            nMis++;
            $display("[TB] FAIL unexpected stop: got stop at cycle %0d, expected none", cyc);
         end else begin
            e = sb.pop_front();
            checkOutput("LO",        w_DIVLO, e.lo);
            checkOutput("HI",        w_DIVHI, e.hi);
            checkOutput("zero flag", {31'b0, w_DivZero}, {31'b0, e.zero});
            checkOutput("stop cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Drive one start pulse, then scramble the operand inputs to show that
   // the operands in flight are held internally. When expectStop is set the
   // expected response is queued with its stop cycle.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expLo, input logic [31:0] expHi,
                                input logic expZero, input bit expectStop);
      exp_t e;
      @(negedge Clock);
      w_A        = a;
      w_B        = b;
      w_DivStart = 1'b1;
      @(posedge Clock);
      #1;
      if (expectStop) begin
         e.lo   = expLo;
         e.hi   = expHi;
         e.zero = expZero;
         e.cyc  = cyc + (expZero ? 1 : 33);
         sb.push_back(e);
      end
      @(negedge Clock);
      w_DivStart = 1'b0;
      w_A        = $urandom;
      w_B        = $urandom;
   endtask

   // Bounded wait for the scoreboard to drain, then let the FSM reach IDLE.
   task automatic waitDone();
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge Clock);
         n++;
      end
      if (sb.size() != 0) begin
         nCmp++;
         nMis++;
         $display("[TB] FAIL timeout: got %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
      repeat (3) @(negedge Clock);
   endtask

   // Main directed sequence.
   initial begin
      Reset      = 1'b1;
      w_DivStart = 1'b0;
      w_A        = '0;
      w_B        = '0;
`ifdef DIV_UNSIGNED_EN
      divUns     = 1'b0;
`endif
      repeat (3) @(negedge Clock);
      checkOutput("reset LO",   w_DIVLO, 32'h0);
      checkOutput("reset HI",   w_DIVHI, 32'h0);
      checkOutput("reset stop", {31'b0, w_DivStop}, 32'h0);
      checkOutput("reset zero", {31'b0, w_DivZero}, 32'h0);
      Reset = 1'b0;
      @(negedge Clock);

      // Signed divisions with hand-computed results.
      applyStimulus(32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b1); waitDone();
      applyStimulus(32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b1); waitDone();
      applyStimulus(32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b1); waitDone();
      applyStimulus(32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0, 1'b1); waitDone();
      applyStimulus(32'd7,        32'd100,      32'd0,        32'd7,        1'b0, 1'b1); waitDone();
      applyStimulus(32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 1'b1); waitDone();
      applyStimulus(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1); waitDone();
      applyStimulus(32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0, 1'b1); waitDone();
      applyStimulus(32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b1); waitDone();

      // Divide by zero keeps the previous 14/2 result on HI/LO.
      applyStimulus(32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b1); waitDone();
      applyStimulus(32'd5,        32'd0,        32'd14,       32'd2,        1'b1, 1'b1); waitDone();

      // Abort: start at E0, ignored re-start at E10, reset sampled at E20.
      applyStimulus(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
      repeat (9) @(negedge Clock);
      w_A        = 32'd9;
      w_B        = 32'd3;
      w_DivStart = 1'b1;
      @(negedge Clock);
      w_DivStart = 1'b0;
      repeat (9) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      checkOutput("abort LO",   w_DIVLO, 32'h0);
      checkOutput("abort HI",   w_DIVHI, 32'h0);
      checkOutput("abort stop", {31'b0, w_DivStop}, 32'h0);
      checkOutput("abort zero", {31'b0, w_DivZero}, 32'h0);
      repeat (45) @(negedge Clock);

      // A fresh division after the abort completes normally.
      applyStimulus(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1); waitDone();

`ifdef DIV_UNSIGNED_EN
      // DIVU versus DIV on the same operands.
      divUns = 1'b1;
      applyStimulus(32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1,        1'b0, 1'b1); waitDone();
      divUns = 1'b0;
      applyStimulus(32'hFFFFFFFF, 32'd2, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b1); waitDone();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nCmp, nMis);
      $finish;
   end

endmodule
